// File: rtl/lrrr_boss_ctrl.sv
// Lrrr boss-fight sequencer: entry, fight (vertical toggling and shots), hit flash, death.
// Drives the boss mover, the missile request handshake and the boss draw enables.
module lrrr_boss_ctrl #(
    parameter int ENTER_FRAMES  = 60,
    parameter int TOGGLE_PERIOD = 45,
    parameter int SHOT_PERIOD   = 30,
    parameter int BOSS_HP       = 5,
    parameter int FLASH_FRAMES  = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startBoss,
    input  logic       bossHit,
    input  logic       shotAck,
    input  logic       gameOver,
    output logic       waiting,
    output logic       toggleY,
    output logic       shotReq,
    output logic       bossVisible,
    output logic       bossFlash,
    output logic       bossDefeated,
    output logic [2:0] hpLeft,
    output logic [2:0] stateOut
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENTER     = 3'd1,
        ST_FIGHT     = 3'd2,
        ST_HIT_FLASH = 3'd3,
        ST_DYING     = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam logic [7:0] ENTER_LIM  = 8'(ENTER_FRAMES);
    localparam logic [7:0] TOGGLE_LIM = 8'(TOGGLE_PERIOD);
    localparam logic [7:0] SHOT_LIM   = 8'(SHOT_PERIOD);
    localparam logic [7:0] FLASH_LIM  = 8'(FLASH_FRAMES);
    localparam logic [7:0] DYING_LIM  = 8'(2 * FLASH_FRAMES);
    localparam logic [2:0] HP_INIT    = 3'(BOSS_HP);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] frame_q, frame_d;
    logic [7:0] tog_q, tog_d;
    logic [7:0] shot_cnt_q, shot_cnt_d;
    logic [2:0] hp_q, hp_d;
    logic       shot_req_q, shot_req_d;
    logic       toggle_q, toggle_d;
    logic       waiting_q, waiting_d;
    logic       visible_q, visible_d;
    logic       flash_q, flash_d;
    logic       defeated_q, defeated_d;

    logic [7:0] frame_nxt, tog_nxt, shot_nxt;

    assign frame_nxt = sat_inc(frame_q);
    assign tog_nxt   = sat_inc(tog_q);
    assign shot_nxt  = sat_inc(shot_cnt_q);

    // Period events fire on the frame pulse that brings a counter up to its limit.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        hp_d       = hp_q;
        tog_d      = tog_q;
        shot_cnt_d = shot_cnt_q;
        shot_req_d = shot_req_q;
        toggle_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (startBoss) begin
                    state_d = ST_ENTER;
                    hp_d    = HP_INIT;
                end
            end
            ST_ENTER: begin
                if (startOfFrame && (frame_nxt >= ENTER_LIM)) state_d = ST_FIGHT;
            end
            ST_FIGHT: begin
                if (bossHit) begin
                    // A hit wins over any counter event in the same cycle.
                    if (hp_q > 3'd1) begin
                        hp_d    = hp_q - 3'd1;
                        state_d = ST_HIT_FLASH;
                    end else begin
                        hp_d    = 3'd0;
                        state_d = ST_DYING;
                    end
                end else begin
                    if (startOfFrame) begin
                        if (tog_nxt >= TOGGLE_LIM) begin
                            tog_d    = 8'd0;
                            toggle_d = 1'b1;
                        end else begin
                            tog_d = tog_nxt;
                        end
                    end
                    if (shot_req_q) begin
                        if (shotAck) shot_req_d = 1'b0;
                    end else if (startOfFrame) begin
                        if (shot_nxt >= SHOT_LIM) begin
                            shot_req_d = 1'b1;
                            shot_cnt_d = 8'd0;
                        end else begin
                            shot_cnt_d = shot_nxt;
                        end
                    end
                end
            end
            ST_HIT_FLASH: begin
                if (startOfFrame && (frame_nxt >= FLASH_LIM)) state_d = ST_FIGHT;
            end
            ST_DYING: begin
                if (startOfFrame && (frame_nxt >= DYING_LIM)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!startBoss) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (gameOver && (state_q != ST_IDLE)) state_d = ST_IDLE;

        // Leaving FIGHT discards any pending shot; counters survive only the hit flash.
        if (state_d != ST_FIGHT) begin
            shot_req_d = 1'b0;
            toggle_d   = 1'b0;
        end
        if ((state_d != ST_FIGHT) && (state_d != ST_HIT_FLASH)) begin
            tog_d      = 8'd0;
            shot_cnt_d = 8'd0;
        end

        if (state_d != state_q)  frame_d = 8'd0;
        else if (startOfFrame)   frame_d = frame_nxt;
        else                     frame_d = frame_q;
    end

    always_comb begin
        waiting_d  = state_q inside {ST_IDLE, ST_ENTER, ST_DYING, ST_DONE};
        visible_d  = state_q inside {ST_ENTER, ST_FIGHT, ST_HIT_FLASH, ST_DYING};
        flash_d    = (state_q inside {ST_HIT_FLASH, ST_DYING}) && frame_q[1];
        defeated_d = (state_q == ST_DYING) && (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q    <= ST_IDLE;
            frame_q    <= 8'd0;
            tog_q      <= 8'd0;
            shot_cnt_q <= 8'd0;
            hp_q       <= 3'd0;
            shot_req_q <= 1'b0;
            toggle_q   <= 1'b0;
            waiting_q  <= 1'b1;
            visible_q  <= 1'b0;
            flash_q    <= 1'b0;
            defeated_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            tog_q      <= tog_d;
            shot_cnt_q <= shot_cnt_d;
            hp_q       <= hp_d;
            shot_req_q <= shot_req_d;
            toggle_q   <= toggle_d;
            waiting_q  <= waiting_d;
            visible_q  <= visible_d;
            flash_q    <= flash_d;
            defeated_q <= defeated_d;
        end
    end

    assign waiting      = waiting_q;
    assign toggleY      = toggle_q;
    assign shotReq      = shot_req_q;
    assign bossVisible  = visible_q;
    assign bossFlash    = flash_q;
    assign bossDefeated = defeated_q;
    assign hpLeft       = hp_q;
    assign stateOut     = state_q;

endmodule

// File: tb/tb_lrrr_boss_ctrl.sv
// Directed bench for lrrr_boss_ctrl: hit-point and defeat events go through a scoreboard
// queue; toggle and shot activity is counted by a monitor and checked at fixed frames.
module tb_lrrr_boss_ctrl;

    logic       clk = 1'b0;
    logic       resetN, startOfFrame, startBoss, bossHit, shotAck, gameOver;
    logic       waiting, toggleY, shotReq, bossVisible, bossFlash, bossDefeated;
    logic [2:0] hpLeft, stateOut;

    lrrr_boss_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .startBoss    (startBoss),
        .bossHit      (bossHit),
        .shotAck      (shotAck),
        .gameOver     (gameOver),
        .waiting      (waiting),
        .toggleY      (toggleY),
        .shotReq      (shotReq),
        .bossVisible  (bossVisible),
        .bossFlash    (bossFlash),
        .bossDefeated (bossDefeated),
        .hpLeft       (hpLeft),
        .stateOut     (stateOut)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   sb_q[$];
    int   hp_prev   = 0;
    int   tog_n     = 0;
    int   tog_hi    = 0;
    int   shot_rise = 0;
    int   def_n     = 0;
    int   rise_snap;
    logic tog_prev  = 1'b0;
    logic shot_prev = 1'b0;
    bit   mon_en    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard codes: 16+hp for an hpLeft change, 32 for a defeat pulse.
    task automatic sb_pop(input string tag, input int obs);
        int exp;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        else                 exp = -1;
        check(tag, obs, exp);
    endtask

    task automatic push_hp(input int v);
        sb_q.push_back(16 + v);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(hpLeft) != hp_prev) begin
                sb_pop("hp_event", 16 + int'(hpLeft));
                hp_prev = int'(hpLeft);
            end
            if (bossDefeated === 1'b1) begin
                def_n++;
                sb_pop("defeat_event", 32);
            end
            if (toggleY === 1'b1) begin
                tog_hi++;
                if (!tog_prev) tog_n++;
            end
            if ((shotReq === 1'b1) && !shot_prev) shot_rise++;
            tog_prev  = toggleY;
            shot_prev = shotReq;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        repeat (3) step();
    endtask

    task automatic hit();
        bossHit = 1'b1;
        step();
        bossHit = 1'b0;
    endtask

    task automatic ack();
        shotAck = 1'b1;
        step();
        shotAck = 1'b0;
    endtask

    // Hits issued right as FIGHT resumes, from first_hp down to 0.
    task automatic do_hits(input int first_hp);
        for (int h = first_hp; h >= 0; h--) begin
            push_hp(h);
            hit();
            check($sformatf("hit_state_hp%0d", h), stateOut, (h > 0) ? 32'd3 : 32'd4);
            if (h > 0) begin
                repeat (15) frame();
                check($sformatf("flash_end_hp%0d", h), stateOut, 32'd2);
            end
        end
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        startBoss    = 1'b0;
        bossHit      = 1'b0;
        shotAck      = 1'b0;
        gameOver     = 1'b0;
        #2 resetN = 1'b1;
        step();
        step();
        check("rst_state", stateOut, 0);
        check("rst_hp", hpLeft, 0);
        check("rst_waiting", waiting, 1);
        check("rst_toggle", toggleY, 0);
        check("rst_shot", shotReq, 0);
        check("rst_visible", bossVisible, 0);
        check("rst_flash", bossFlash, 0);
        check("rst_defeated", bossDefeated, 0);
        resetN = 1'b0;
        mon_en = 1'b1;
        step();

        // Entry: ENTER for 60 frames, then FIGHT with full hit points.
        startBoss = 1'b1;
        push_hp(5);
        step();
        check("enter_state", stateOut, 1);
        step();
        check("enter_waiting", waiting, 1);
        check("enter_visible", bossVisible, 1);
        repeat (59) frame();
        check("enter_f59_state", stateOut, 1);
        check("enter_f59_waiting", waiting, 1);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        check("enter_f60_state", stateOut, 2);
        check("enter_f60_waiting", waiting, 1);
        step();
        check("fight_waiting", waiting, 0);
        step();
        step();
        frame();
        check("f61_state", stateOut, 2);
        check("f61_waiting", waiting, 0);
        check("f61_hp", hpLeft, 5);

        // Uninterrupted FIGHT: toggles at fight frames 45 and 90, shots every 30 acked promptly.
        for (int f = 2; f <= 90; f++) begin
            frame();
            if (f == 29) check("shot_f29", shotReq, 0);
            if (f == 44) check("tog_f44", tog_n, 0);
            if (f == 45) check("tog_f45", tog_n, 1);
            if (f == 89) check("tog_f89", tog_n, 1);
            if (f == 90) begin
                check("tog_f90", tog_n, 2);
                check("tog_width", tog_hi, 2);
            end
            if ((f % 30) == 0) begin
                check($sformatf("shot_raise_f%0d", f), shotReq, 1);
                ack();
                check($sformatf("shot_ack_f%0d", f), shotReq, 0);
            end
        end

        // Shot held with no ack for 100 clk, then the next one 30 frames after the ack.
        repeat (29) frame();
        check("shot_f119", shotReq, 0);
        frame();
        check("shot_f120", shotReq, 1);
        rise_snap = shot_rise;
        repeat (25) frame();
        check("shot_hold", shotReq, 1);
        check("shot_single", shot_rise - rise_snap, 0);
        ack();
        check("shot_dropped", shotReq, 0);
        repeat (29) frame();
        check("shot_next_early", shotReq, 0);
        frame();
        check("shot_next", shotReq, 1);

        // Abort with a pending shot.
        gameOver  = 1'b1;
        startBoss = 1'b0;
        step();
        check("abort_state", stateOut, 0);
        check("abort_shot", shotReq, 0);
        gameOver = 1'b0;
        step();
        check("abort_waiting", waiting, 1);
        check("abort_visible", bossVisible, 0);
        check("abort_hp_kept", hpLeft, 5);

        // Re-enter; hit on the same frame pulse as shot expiry.
        startBoss = 1'b1;
        step();
        repeat (60) frame();
        check("reenter_state", stateOut, 2);
        repeat (29) frame();
        check("prio_pre_shot", shotReq, 0);
        push_hp(4);
        startOfFrame = 1'b1;
        bossHit      = 1'b1;
        step();
        startOfFrame = 1'b0;
        bossHit      = 1'b0;
        check("prio_state", stateOut, 3);
        check("prio_shot", shotReq, 0);
        repeat (3) step();
        repeat (2) frame();
        check("flash_bit1_on", bossFlash, 1);
        hit();
        check("invuln_hp", hpLeft, 4);
        check("invuln_state", stateOut, 3);
        repeat (2) frame();
        check("flash_bit1_off", bossFlash, 0);
        repeat (10) frame();
        check("flash_f14_state", stateOut, 3);
        check("flash_shot", shotReq, 0);
        frame();
        check("flash_f15_state", stateOut, 2);
        check("flash_f15_shot", shotReq, 0);
        frame();
        check("shot_after_flash", shotReq, 1);
        ack();

        // Remaining hits down to zero, dying, defeat.
        do_hits(3);
        repeat (29) frame();
        check("dying_f29_state", stateOut, 4);
        check("dying_waiting", waiting, 1);
        check("dying_visible", bossVisible, 1);
        check("dying_no_defeat", def_n, 0);
        sb_q.push_back(32);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        check("done_state", stateOut, 5);
        check("defeat_pulse", bossDefeated, 1);
        step();
        check("defeat_one_clk", bossDefeated, 0);
        hit();
        check("sixth_hit_hp", hpLeft, 0);
        check("sixth_hit_state", stateOut, 5);
        startBoss = 1'b0;
        step();
        check("done_to_idle", stateOut, 0);
        check("defeat_count", def_n, 1);

        // Async reset in the middle of DYING, then resume.
        startBoss = 1'b1;
        push_hp(5);
        step();
        repeat (60) frame();
        check("third_entry_state", stateOut, 2);
        do_hits(4);
        repeat (5) frame();
        #2 resetN = 1'b1;
        #1;
        check("arst_state", stateOut, 0);
        check("arst_hp", hpLeft, 0);
        check("arst_waiting", waiting, 1);
        check("arst_toggle", toggleY, 0);
        check("arst_shot", shotReq, 0);
        check("arst_visible", bossVisible, 0);
        check("arst_flash", bossFlash, 0);
        check("arst_defeated", bossDefeated, 0);
        step();
        step();
        resetN = 1'b0;
        push_hp(5);
        step();
        check("resume_state", stateOut, 1);
        step();
        check("no_defeat_on_reset", def_n, 1);
        check("tog_width_total", tog_hi, tog_n);
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
